// File: rtl/cache_arb_pkg.sv
// ----------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and helpers for the two-master cache port arbiter.
//   master_id_t     : 1-bit master identifier (0 = instruction, 1 = data)
//   arb_state_t     : IDLE / HOLD lock state of the arbiter
//   fifo_cnt_width(): bits needed to count 0..depth outstanding entries
// ----------------------------------------------------------------------------
package cache_arb_pkg;

  typedef logic master_id_t;

  localparam master_id_t MASTER_INSTR = 1'b0;
  localparam master_id_t MASTER_DATA  = 1'b1;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  // The count must represent both "empty" (0) and "full" (depth).
  function automatic int unsigned fifo_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// ----------------------------------------------------------------------------
// arb_id_fifo
// In-order FIFO of master IDs, one entry per granted-but-unanswered transfer.
// The head names the master that owns the next response from the cache.
//   clk, rst_n : clock / asynchronous active-low reset (clears to empty)
//   push_i     : write din_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   din_i      : master ID to enqueue
//   dout_o     : master ID at the head (meaningful only when !empty_o)
//   full_o     : DEPTH entries held, from the registered count
//   empty_o    : no entries held
// ----------------------------------------------------------------------------
module arb_id_fifo
  import cache_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  master_id_t din_i,
  output master_id_t dout_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned CNT_W = fifo_cnt_width(DEPTH);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  master_id_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);

    // A simultaneous push and pop leaves the count unchanged.
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; the count and pointers alone
  // decide validity, and leaving the array reset-free keeps it plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// ----------------------------------------------------------------------------
// cache_port_arbiter
// Shares the cache processor-side port between the instruction fetch (m0) and
// data (m1) ports using the req/gnt/rvalid protocol. Round-robin arbitration;
// a request that the cache stalls is locked in (HOLD) until granted. Responses
// are steered back in order via a FIFO of master IDs.
//   clk, rst_n                 : clock / asynchronous active-low reset
//   mX_req_i / mX_gnt_o        : master request / grant
//   mX_addr_i, mX_we_i,
//   mX_be_i, mX_wdata_i        : master request fields
//   mX_rvalid_o, mX_rdata_o    : master response (rdata shared from cache)
//   s_req_o / s_gnt_i          : request to / grant from the cache
//   s_addr_o, s_we_o,
//   s_be_o, s_wdata_o          : request fields of the selected master
//   s_rvalid_i, s_rdata_i      : cache response
//   err_o                      : sticky flag, response with nothing outstanding
// ----------------------------------------------------------------------------
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // master 0: instruction fetch
  input  logic                    m0_req_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  // master 1: data
  input  logic                    m1_req_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  // cache side
  output logic                    s_req_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);

  arb_state_t state_q, state_d;
  master_id_t lock_id_q, lock_id_d;
  master_id_t rr_ptr_q, rr_ptr_d;
  master_id_t sel;
  master_id_t fifo_head;
  logic       err_q, err_d;
  logic [1:0] req_vec;
  logic       sel_req;
  logic       accept;
  logic       rsp_ok;
  logic       fifo_full, fifo_empty;

  // Requests are masked while reset is asserted so s_req_o drops at once and
  // the field mux falls back to rr_ptr (= m0) during reset.
  assign req_vec = {m1_req_i, m0_req_i} & {2{rst_n}};

  // Selected master: the locked one in HOLD, otherwise priority holder first.
  always_comb begin
    sel = rr_ptr_q;
    if (state_q == ARB_HOLD)      sel = lock_id_q;
    else if (req_vec[rr_ptr_q])   sel = rr_ptr_q;
    else if (req_vec[~rr_ptr_q])  sel = ~rr_ptr_q;
  end

  assign sel_req = req_vec[sel];
  assign accept  = s_req_o & s_gnt_i;
  assign rsp_ok  = s_rvalid_i & ~fifo_empty;

  // --------------------------------------------------------------------------
  // Lock FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      lock_id_q <= MASTER_INSTR;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    unique case (state_q)
      ARB_IDLE: begin
        // A stalled request is frozen so its fields stay stable until granted.
        if (s_req_o && !s_gnt_i) begin
          state_d   = ARB_HOLD;
          lock_id_d = sel;
        end
      end
      ARB_HOLD: begin
        // While the FIFO is full s_req_o is low, so the lock simply persists.
        if (accept) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_req_o     = sel_req & ~fifo_full;
    m0_gnt_o    = s_gnt_i & s_req_o & (sel == MASTER_INSTR);
    m1_gnt_o    = s_gnt_i & s_req_o & (sel == MASTER_DATA);
    m0_rvalid_o = rsp_ok & (fifo_head == MASTER_INSTR);
    m1_rvalid_o = rsp_ok & (fifo_head == MASTER_DATA);
    s_addr_o    = (sel == MASTER_DATA) ? m1_addr_i  : m0_addr_i;
    s_we_o      = (sel == MASTER_DATA) ? m1_we_i    : m0_we_i;
    s_be_o      = (sel == MASTER_DATA) ? m1_be_i    : m0_be_i;
    s_wdata_o   = (sel == MASTER_DATA) ? m1_wdata_i : m0_wdata_i;
  end

  assign m0_rdata_o = s_rdata_i;
  assign m1_rdata_o = s_rdata_i;
  assign err_o      = err_q;

  // --------------------------------------------------------------------------
  // Round-robin pointer and sticky error
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = accept ? ~sel : rr_ptr_q;
    err_d    = err_q | (s_rvalid_i & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= MASTER_INSTR;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding-transfer ID FIFO
  // --------------------------------------------------------------------------
  arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (rsp_ok),
    .din_i   (sel),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
